// File: rtl/aes_uart_pkg.sv
// Shared definitions for the UART -> AES block path.
// Contents: default frame header bytes, AES block width, payload bytes per
// block, and the assembler state type.
package aes_uart_pkg;

  localparam logic [7:0]  HDR_KEY_DEF  = 8'h4B;
  localparam logic [7:0]  HDR_TEXT_DEF = 8'h50;
  localparam int unsigned AES_BLK_W    = 128;
  localparam int unsigned BLK_BYTES    = 16;

  typedef enum logic {
    IDLE,
    COLLECT
  } asm_state_t;

endpackage

// File: rtl/uart_byte_strobe.sv
// Byte strobe generator for a UART receiver whose valid output is a level.
// Emits a one-cycle strobe on each rising edge of the valid level and
// presents the received byte in that same cycle.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_data         receiver byte (stable while i_valid is high)
//   i_valid        receiver valid level
//   o_stb          one-cycle strobe per received byte
//   o_data         byte belonging to the strobe
module uart_byte_strobe (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_stb,
  output logic [7:0] o_data
);

  logic r_valid_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_valid_q <= 1'b0;
    else       r_valid_q <= i_valid;
  end

  // r_valid_q is 0 out of reset, so a byte already valid at release still
  // produces exactly one strobe.
  assign o_stb  = i_valid & ~r_valid_q;
  // The receiver holds the byte stable while valid, so the strobe-cycle
  // value is taken directly without an extra register stage.
  assign o_data = i_data;

endmodule

// File: rtl/uart_block_assembler.sv
// Assembles header-framed UART byte streams into 128-bit AES blocks.
// Frame: one header byte (HDR_KEY or HDR_TEXT) followed by 16 payload bytes;
// first payload byte lands in blk_data[127:120].
// Ports:
//   uart_clock, uart_reset  clock, asynchronous active-high reset
//   rx_data, rx_valid       receiver byte and valid level
//   blk_data, blk_is_key    assembled block and its type
//   blk_valid, blk_ready    output handshake to the AES core
//   err_hdr, err_timeout    one-cycle error pulses
//   err_overrun, err_clear  sticky dropped-frame flag and its clear
module uart_block_assembler
  import aes_uart_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000,
  parameter logic [7:0]  HDR_KEY        = HDR_KEY_DEF,
  parameter logic [7:0]  HDR_TEXT       = HDR_TEXT_DEF
) (
  input  logic                 uart_clock,
  input  logic                 uart_reset,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [AES_BLK_W-1:0] blk_data,
  output logic                 blk_is_key,
  output logic                 blk_valid,
  input  logic                 blk_ready,
  output logic                 err_hdr,
  output logic                 err_timeout,
  output logic                 err_overrun,
  input  logic                 err_clear
);

  localparam logic [23:0] TMO_LAST = TIMEOUT_CYCLES - 24'd1;
  localparam logic [3:0]  LAST_IDX = 4'(BLK_BYTES - 1);

  asm_state_t r_state;
  asm_state_t w_state_nxt;

  logic [3:0]   r_byte_cnt;
  logic [23:0]  r_tmo_cnt;
  logic         r_is_key;
  // Only the first 15 payload bytes are stored; the 16th is taken straight
  // from the strobe cycle when the block is loaded.
  logic [119:0] r_asm;

  logic       w_stb;
  logic [7:0] w_byte;
  logic       w_hdr_ok;
  logic       w_hdr_bad;
  logic       w_shift;
  logic       w_last;
  logic       w_tmo_inc;
  logic       w_tmo_fire;
  logic       w_slot_free;
  logic       w_load;
  logic       w_drop;

  uart_byte_strobe u_strobe (
    .i_clk   (uart_clock),
    .i_rst   (uart_reset),
    .i_data  (rx_data),
    .i_valid (rx_valid),
    .o_stb   (w_stb),
    .o_data  (w_byte)
  );

  always_ff @(posedge uart_clock or posedge uart_reset) begin
    if (uart_reset) r_state <= IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hdr_ok    = 1'b0;
    w_hdr_bad   = 1'b0;
    w_shift     = 1'b0;
    w_last      = 1'b0;
    w_tmo_inc   = 1'b0;
    w_tmo_fire  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_stb) begin
          if ((w_byte == HDR_KEY) || (w_byte == HDR_TEXT)) begin
            w_hdr_ok    = 1'b1;
            w_state_nxt = COLLECT;
          end else begin
            w_hdr_bad = 1'b1;
          end
        end
      end
      COLLECT: begin
        // A strobe takes priority over an expiring timeout.
        if (w_stb) begin
          w_shift = 1'b1;
          if (r_byte_cnt == LAST_IDX) begin
            w_last      = 1'b1;
            w_state_nxt = IDLE;
          end
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_tmo_fire  = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_tmo_inc = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // The slot also counts as free when the pending block is accepted in
    // this very cycle, allowing back-to-back loads.
    w_slot_free = ~blk_valid | blk_ready;
    w_load      = w_last & w_slot_free;
    w_drop      = w_last & ~w_slot_free;
  end

  always_ff @(posedge uart_clock or posedge uart_reset) begin
    if (uart_reset) begin
      r_byte_cnt  <= '0;
      r_tmo_cnt   <= '0;
      r_is_key    <= 1'b0;
      r_asm       <= '0;
      blk_data    <= '0;
      blk_is_key  <= 1'b0;
      blk_valid   <= 1'b0;
      err_hdr     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (w_hdr_ok) begin
        r_is_key   <= (w_byte == HDR_KEY);
        r_byte_cnt <= '0;
        r_tmo_cnt  <= '0;
      end

      if (w_shift) begin
        r_asm      <= {r_asm[111:0], w_byte};
        r_byte_cnt <= r_byte_cnt + 4'd1;
        r_tmo_cnt  <= '0;
      end else if (w_tmo_inc) begin
        r_tmo_cnt <= r_tmo_cnt + 24'd1;
      end else if (w_tmo_fire) begin
        r_tmo_cnt <= '0;
      end

      err_hdr     <= w_hdr_bad;
      err_timeout <= w_tmo_fire;

      if (w_load) begin
        blk_data   <= {r_asm, w_byte};
        blk_is_key <= r_is_key;
        blk_valid  <= 1'b1;
      end else if (blk_valid && blk_ready) begin
        blk_valid <= 1'b0;
      end

      if (w_drop)         err_overrun <= 1'b1;
      else if (err_clear) err_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_block_assembler.sv
module tb_uart_block_assembler;

  localparam logic [7:0] HK = 8'h4B;
  localparam logic [7:0] HT = 8'h50;

  logic         uart_clock = 1'b0;
  logic         uart_reset = 1'b1;
  logic [7:0]   rx_data    = '0;
  logic         rx_valid   = 1'b0;
  logic [127:0] blk_data;
  logic         blk_is_key;
  logic         blk_valid;
  logic         blk_ready  = 1'b0;
  logic         err_hdr;
  logic         err_timeout;
  logic         err_overrun;
  logic         err_clear  = 1'b0;

  always #5 uart_clock = ~uart_clock;

  uart_block_assembler #(.TIMEOUT_CYCLES(24'd100)) dut (
    .uart_clock  (uart_clock),
    .uart_reset  (uart_reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .blk_data    (blk_data),
    .blk_is_key  (blk_is_key),
    .blk_valid   (blk_valid),
    .blk_ready   (blk_ready),
    .err_hdr     (err_hdr),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun),
    .err_clear   (err_clear)
  );

  typedef struct {
    logic         is_key;
    logic [127:0] data;
  } blk_t;

  blk_t exp_q[$];
  blk_t got_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int exp_hdr  = 0;
  int exp_tmo  = 0;

  // monitor state
  int           hdr_cycles = 0;
  int           tmo_cycles = 0;
  int           long_pulses = 0;
  int           unstable = 0;
  logic         prev_hdr = 1'b0;
  logic         prev_tmo = 1'b0;
  logic         prev_hold = 1'b0;
  logic [127:0] prev_data = '0;
  logic         prev_key = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge uart_clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned hold, input int unsigned gap);
    rx_data  = b;
    rx_valid = 1'b1;
    repeat (hold) step();
    rx_valid = 1'b0;
    repeat (gap) step();
  endtask

  // Payload byte slow_idx is followed by an idle gap that puts the next
  // strobe exactly on the timeout cycle.
  task automatic send_frame(input logic [7:0] hdr, input logic [127:0] pl,
                            input int unsigned hold, input int unsigned gap,
                            input int unsigned slow_idx, input bit clr_last);
    logic [7:0] b;
    send_byte(hdr, hold, gap);
    for (int unsigned i = 0; i < 16; i++) begin
      b = pl[127 - 8*i -: 8];
      if (i == 15) begin
        rx_data   = b;
        rx_valid  = 1'b1;
        err_clear = clr_last;
        step();
        err_clear = 1'b0;
        repeat (hold - 1) step();
        rx_valid = 1'b0;
        repeat (gap) step();
      end else begin
        send_byte(b, hold, (i == slow_idx) ? (100 - hold) : gap);
      end
    end
  endtask

  task automatic expect_blk(input logic [7:0] hdr, input logic [127:0] pl);
    blk_t e;
    e.is_key = (hdr == HK);
    e.data   = pl;
    exp_q.push_back(e);
  endtask

  task automatic drain_check(input string tag);
    blk_t g;
    blk_t e;
    check({tag, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_data"}, g.data, e.data);
      check({tag, "_key"}, 128'(g.is_key), 128'(e.is_key));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [127:0] rand_payload(input bit with_hdr_bytes);
    logic [127:0] p;
    logic [7:0]   b;
    p = '0;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      if (with_hdr_bytes && ($urandom_range(0, 3) == 0)) b = ($urandom_range(0, 1) == 0) ? HK : HT;
      p = {p[119:0], b};
    end
    return p;
  endfunction

  // Monitor: samples on the falling edge, between drive points.
  initial begin
    blk_t a;
    forever begin
      @(negedge uart_clock);
      if (uart_reset) begin
        prev_hdr  = 1'b0;
        prev_tmo  = 1'b0;
        prev_hold = 1'b0;
      end else begin
        if (err_hdr) hdr_cycles++;
        if (err_timeout) tmo_cycles++;
        if ((err_hdr && prev_hdr) || (err_timeout && prev_tmo)) long_pulses++;
        prev_hdr = err_hdr;
        prev_tmo = err_timeout;
        if (blk_valid && blk_ready) begin
          a.is_key = blk_is_key;
          a.data   = blk_data;
          got_q.push_back(a);
          prev_hold = 1'b0;
        end else if (blk_valid) begin
          if (prev_hold && (blk_data !== prev_data || blk_is_key !== prev_key)) unstable++;
          prev_hold = 1'b1;
          prev_data = blk_data;
          prev_key  = blk_is_key;
        end else begin
          prev_hold = 1'b0;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] pl;
    logic [127:0] pa;
    logic [7:0]   h;
    int unsigned  kind;
    int unsigned  n;

    // reset state
    repeat (3) step();
    check("rst_valid", 128'(blk_valid), 128'(1'b0));
    check("rst_data", blk_data, 128'h0);
    check("rst_errs", 128'({err_hdr, err_timeout, err_overrun, blk_is_key}), 128'(4'b0));
    uart_reset = 1'b0;
    step();

    // key frame 00..0F, one-cycle latency
    send_byte(HK, 1, 1);
    for (int i = 0; i < 15; i++) send_byte(8'(i), 1, 1);
    rx_data  = 8'h0F;
    rx_valid = 1'b1;
    check("t1_pre_valid", 128'(blk_valid), 128'(1'b0));
    step();
    check("t1_valid_lat", 128'(blk_valid), 128'(1'b1));
    check("t1_data", blk_data, 128'h000102030405060708090A0B0C0D0E0F);
    check("t1_key", 128'(blk_is_key), 128'(1'b1));
    expect_blk(HK, 128'h000102030405060708090A0B0C0D0E0F);
    rx_valid  = 1'b0;
    blk_ready = 1'b1;
    step();
    blk_ready = 1'b0;
    check("t1_valid_drop", 128'(blk_valid), 128'(1'b0));
    drain_check("t1");

    // long rx_valid hold: one byte per rising edge only
    blk_ready = 1'b1;
    pl = {16{8'hAA}};
    expect_blk(HT, pl);
    send_frame(HT, pl, 20, 2, 99, 1'b0);
    repeat (3) step();
    drain_check("t2");
    check("t2_no_hdr_err", 128'(hdr_cycles), 128'(exp_hdr));

    // bad header then valid frame
    send_byte(8'h33, 1, 2);
    exp_hdr++;
    pl = rand_payload(1'b1);
    expect_blk(HT, pl);
    send_frame(HT, pl, 1, 1, 99, 1'b0);
    repeat (3) step();
    check("t3_hdr_pulses", 128'(hdr_cycles), 128'(exp_hdr));
    drain_check("t3");

    // timeout after partial frame, then a clean frame
    send_byte(HK, 1, 1);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1, 1);
    repeat (110) step();
    exp_tmo++;
    check("t4_tmo_pulses", 128'(tmo_cycles), 128'(exp_tmo));
    check("t4_no_blk", 128'(blk_valid), 128'(1'b0));
    pl = rand_payload(1'b0);
    expect_blk(HT, pl);
    send_frame(HT, pl, 1, 2, 99, 1'b0);
    repeat (3) step();
    drain_check("t4");

    // byte landing on the timeout cycle wins
    pl = rand_payload(1'b0);
    expect_blk(HK, pl);
    send_frame(HK, pl, 1, 1, 6, 1'b0);
    repeat (3) step();
    check("t4b_no_tmo", 128'(tmo_cycles), 128'(exp_tmo));
    drain_check("t4b");

    // overrun: first block held, second dropped, set beats clear
    blk_ready = 1'b0;
    pa = rand_payload(1'b0);
    expect_blk(HK, pa);
    send_frame(HK, pa, 1, 1, 99, 1'b0);
    send_frame(HT, rand_payload(1'b0), 1, 1, 99, 1'b0);
    step();
    check("t5_overrun_set", 128'(err_overrun), 128'(1'b1));
    check("t5_held_data", blk_data, pa);
    check("t5_held_key", 128'(blk_is_key), 128'(1'b1));
    send_frame(HT, rand_payload(1'b0), 1, 1, 99, 1'b1);
    check("t5_set_wins", 128'(err_overrun), 128'(1'b1));
    blk_ready = 1'b1;
    step();
    blk_ready = 1'b0;
    check("t5_valid_drop", 128'(blk_valid), 128'(1'b0));
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    check("t5_overrun_clr", 128'(err_overrun), 128'(1'b0));
    drain_check("t5");

    // reset with a pending block and a partial frame
    send_frame(HK, rand_payload(1'b0), 1, 1, 99, 1'b0);
    send_byte(HK, 1, 1);
    for (int i = 0; i < 7; i++) send_byte(8'($urandom), 1, 1);
    uart_reset = 1'b1;
    #1;
    check("t6_rst_valid", 128'(blk_valid), 128'(1'b0));
    check("t6_rst_data", blk_data, 128'h0);
    check("t6_rst_flags", 128'({blk_is_key, err_hdr, err_timeout, err_overrun}), 128'(4'b0));
    step();
    uart_reset = 1'b0;
    blk_ready  = 1'b1;
    pl = rand_payload(1'b1);
    expect_blk(HT, pl);
    send_frame(HT, pl, 1, 1, 99, 1'b0);
    repeat (3) step();
    drain_check("t6");

    // randomized frames against the scoreboard
    for (int f = 0; f < 30; f++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        do h = 8'($urandom); while (h == HK || h == HT);
        send_byte(h, $urandom_range(1, 3), $urandom_range(1, 4));
        exp_hdr++;
      end else if (kind == 1) begin
        send_byte(($urandom_range(0, 1) == 0) ? HK : HT, 1, 1);
        n = $urandom_range(0, 15);
        for (int unsigned i = 0; i < n; i++) send_byte(8'($urandom), 1, 1);
        repeat (105) step();
        exp_tmo++;
      end else begin
        h  = ($urandom_range(0, 1) == 0) ? HK : HT;
        pl = rand_payload(1'b1);
        expect_blk(h, pl);
        send_frame(h, pl, $urandom_range(1, 3), $urandom_range(1, 4), 99, 1'b0);
      end
    end
    repeat (5) step();
    drain_check("rnd");
    check("rnd_hdr_pulses", 128'(hdr_cycles), 128'(exp_hdr));
    check("rnd_tmo_pulses", 128'(tmo_cycles), 128'(exp_tmo));
    check("pulse_width", 128'(long_pulses), 128'(0));
    check("hold_stable", 128'(unstable), 128'(0));
    check("no_overrun", 128'(err_overrun), 128'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
